// File: rtl/rc4_session_ctrl.sv
// Session sequencer around a standalone RC4 keystream core: forwards the key, then runs an
// encrypt pass and a decrypt pass over the same length, restarting the core between passes.
module rc4_session_ctrl #(
    parameter int unsigned MAX_LEN = 2048,
    parameter int unsigned LEN_W   = 12,
    parameter int unsigned KEY_MAX = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       key_valid_i,
    input  logic [7:0] key_in_i,
    output logic       plain_read_o,
    input  logic       plain_in_valid_i,
    input  logic [7:0] plain_in_i,
    output logic       cipher_write_o,
    output logic [7:0] cipher_out_o,
    output logic       cipher_read_o,
    input  logic       cipher_in_valid_i,
    input  logic [7:0] cipher_in_i,
    output logic       plain_write_o,
    output logic [7:0] plain_out_o,
    output logic       ks_key_valid_o,
    output logic [7:0] ks_key_in_o,
    output logic       ks_start_o,
    input  logic       ks_ready_i,
    output logic       ks_req_o,
    input  logic       ks_vld_i,
    input  logic [7:0] ks_byte_i,
    output logic       done_o,
    output logic       err_o
);

    localparam int unsigned KeyLenW = $clog2(KEY_MAX + 1);
    localparam logic [LEN_W-1:0]   MaxLenC = LEN_W'(MAX_LEN);
    localparam logic [KeyLenW-1:0] KeyMaxC = KeyLenW'(KEY_MAX);

    typedef enum logic [3:0] {
        StIdle, StKey, StInitE, StERd, StEKs, StEWr, StInitD, StDRd, StDKs, StDWr, StDone
    } state_e;

    state_e             state_q;
    logic [LEN_W-1:0]   n_q;
    logic [LEN_W-1:0]   msg_len_q;
    logic [KeyLenW-1:0] key_len_q;
    logic [7:0]         data_q;
    logic               plain_read_q, cipher_write_q, cipher_read_q, plain_write_q;
    logic [7:0]         cipher_out_q, plain_out_q;
    logic               ks_key_valid_q, ks_start_q, ks_req_q, done_q, err_q;
    logic [7:0]         ks_key_in_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            n_q            <= '0;
            msg_len_q      <= '0;
            key_len_q      <= '0;
            data_q         <= '0;
            plain_read_q   <= 1'b0;
            cipher_write_q <= 1'b0;
            cipher_read_q  <= 1'b0;
            plain_write_q  <= 1'b0;
            cipher_out_q   <= '0;
            plain_out_q    <= '0;
            ks_key_valid_q <= 1'b0;
            ks_key_in_q    <= '0;
            ks_start_q     <= 1'b0;
            ks_req_q       <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            // Strobes are single-cycle; each state raises the one it needs on exit.
            plain_read_q   <= 1'b0;
            cipher_write_q <= 1'b0;
            cipher_read_q  <= 1'b0;
            plain_write_q  <= 1'b0;
            ks_key_valid_q <= 1'b0;
            ks_start_q     <= 1'b0;
            ks_req_q       <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (key_valid_i) begin
                        ks_key_valid_q <= 1'b1;
                        ks_key_in_q    <= key_in_i;
                        key_len_q      <= KeyLenW'(1);
                        state_q        <= StKey;
                    end
                end
                StKey: begin
                    if (key_valid_i) begin
                        if (key_len_q != KeyMaxC) begin
                            ks_key_valid_q <= 1'b1;
                            ks_key_in_q    <= key_in_i;
                            key_len_q      <= key_len_q + KeyLenW'(1);
                        end
                    end else begin
                        ks_start_q <= 1'b1;
                        n_q        <= '0;
                        state_q    <= StInitE;
                    end
                end
                StInitE: begin
                    // ks_ready may still be stale from before ks_start, so skip the entry cycle.
                    if (!ks_start_q && ks_ready_i) begin
                        plain_read_q <= 1'b1;
                        state_q      <= StERd;
                    end
                end
                StERd: begin
                    if (plain_in_valid_i) begin
                        data_q   <= plain_in_i;
                        n_q      <= n_q + LEN_W'(1);
                        ks_req_q <= 1'b1;
                        state_q  <= StEKs;
                    end else if (n_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        msg_len_q  <= n_q;
                        n_q        <= '0;
                        ks_start_q <= 1'b1;
                        state_q    <= StInitD;
                    end
                end
                StEKs: begin
                    if (!ks_req_q && ks_vld_i) begin
                        cipher_out_q   <= data_q ^ ks_byte_i;
                        cipher_write_q <= 1'b1;
                        state_q        <= StEWr;
                    end
                end
                StEWr: begin
                    if (n_q == MaxLenC) begin
                        msg_len_q  <= n_q;
                        n_q        <= '0;
                        ks_start_q <= 1'b1;
                        state_q    <= StInitD;
                    end else begin
                        plain_read_q <= 1'b1;
                        state_q      <= StERd;
                    end
                end
                StInitD: begin
                    if (!ks_start_q && ks_ready_i) begin
                        cipher_read_q <= 1'b1;
                        state_q       <= StDRd;
                    end
                end
                StDRd: begin
                    if (cipher_in_valid_i) begin
                        data_q   <= cipher_in_i;
                        n_q      <= n_q + LEN_W'(1);
                        ks_req_q <= 1'b1;
                        state_q  <= StDKs;
                    end else begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDKs: begin
                    if (!ks_req_q && ks_vld_i) begin
                        plain_out_q   <= data_q ^ ks_byte_i;
                        plain_write_q <= 1'b1;
                        state_q       <= StDWr;
                    end
                end
                StDWr: begin
                    if (n_q == msg_len_q) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cipher_read_q <= 1'b1;
                        state_q       <= StDRd;
                    end
                end
                StDone: begin
                    state_q <= StDone;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign plain_read_o   = plain_read_q;
    assign cipher_write_o = cipher_write_q;
    assign cipher_out_o   = cipher_out_q;
    assign cipher_read_o  = cipher_read_q;
    assign plain_write_o  = plain_write_q;
    assign plain_out_o    = plain_out_q;
    assign ks_key_valid_o = ks_key_valid_q;
    assign ks_key_in_o    = ks_key_in_q;
    assign ks_start_o     = ks_start_q;
    assign ks_req_o       = ks_req_q;
    assign done_o         = done_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_rc4_session_ctrl.sv
// Directed bench for rc4_session_ctrl with a behavioural keystream core and byte-stream host.
module tb_rc4_session_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [7:0] key_in;
    logic       plain_read, plain_in_valid;
    logic [7:0] plain_in;
    logic       cipher_write;
    logic [7:0] cipher_out;
    logic       cipher_read, cipher_in_valid;
    logic [7:0] cipher_in;
    logic       plain_write;
    logic [7:0] plain_out;
    logic       ks_key_valid;
    logic [7:0] ks_key_in;
    logic       ks_start, ks_ready, ks_req, ks_vld;
    logic [7:0] ks_byte;
    logic       done, err;
    logic [32:0] all_out;

    always #5 clk = ~clk;

    rc4_session_ctrl #(
        .MAX_LEN (4),
        .LEN_W   (12),
        .KEY_MAX (4)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .key_valid_i       (key_valid),
        .key_in_i          (key_in),
        .plain_read_o      (plain_read),
        .plain_in_valid_i  (plain_in_valid),
        .plain_in_i        (plain_in),
        .cipher_write_o    (cipher_write),
        .cipher_out_o      (cipher_out),
        .cipher_read_o     (cipher_read),
        .cipher_in_valid_i (cipher_in_valid),
        .cipher_in_i       (cipher_in),
        .plain_write_o     (plain_write),
        .plain_out_o       (plain_out),
        .ks_key_valid_o    (ks_key_valid),
        .ks_key_in_o       (ks_key_in),
        .ks_start_o        (ks_start),
        .ks_ready_i        (ks_ready),
        .ks_req_o          (ks_req),
        .ks_vld_i          (ks_vld),
        .ks_byte_i         (ks_byte),
        .done_o            (done),
        .err_o             (err)
    );

    assign all_out = {plain_read, cipher_write, cipher_out, cipher_read, plain_write, plain_out,
                      ks_key_valid, ks_key_in, ks_start, ks_req, done, err};

    int checks = 0;
    int failures = 0;
    logic [7:0] ks_tab [8];
    logic [7:0] host_p [8];
    logic [7:0] host_c [8];
    logic [7:0] cap_k [8];
    logic [7:0] cap_c [8];
    logic [7:0] cap_p [8];
    int host_plen, host_clen, pidx, cidx, ks_idx, rdy_cnt;
    bit ks_pend;
    int n_kv, n_start, n_req, n_pr, n_cw, n_cr, n_pw, n_overlap;

    // One clock: sample registered outputs 1ns after the edge and answer as host and core.
    task automatic step();
        @(posedge clk);
        #1;
        ks_vld = 1'b0;
        if (ks_pend) begin
            ks_vld  = 1'b1;
            ks_byte = ks_tab[ks_idx % 8];
            ks_idx++;
            ks_pend = 1'b0;
        end
        if (ks_req) begin
            ks_pend = 1'b1;
            n_req++;
        end
        if (ks_start) begin
            n_start++;
            ks_idx   = 0;
            ks_ready = 1'b0;
            rdy_cnt  = 3;
        end else if (rdy_cnt != 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0) ks_ready = 1'b1;
        end
        plain_in_valid = 1'b0;
        if (plain_read) begin
            n_pr++;
            if (pidx < host_plen) begin
                plain_in_valid = 1'b1;
                plain_in       = host_p[pidx];
                pidx++;
            end
        end
        cipher_in_valid = 1'b0;
        if (cipher_read) begin
            n_cr++;
            if (cidx < host_clen) begin
                cipher_in_valid = 1'b1;
                cipher_in       = host_c[cidx];
                cidx++;
            end
        end
        if (ks_key_valid) begin
            if (n_kv < 8) cap_k[n_kv] = ks_key_in;
            n_kv++;
        end
        if (cipher_write) begin
            if (n_cw < 8) cap_c[n_cw] = cipher_out;
            n_cw++;
        end
        if (plain_write) begin
            if (n_pw < 8) cap_p[n_pw] = plain_out;
            n_pw++;
        end
        if ((plain_read || cipher_read) && (cipher_write || plain_write)) n_overlap++;
    endtask

    task automatic clear_model();
        pidx = 0; cidx = 0; ks_idx = 0; rdy_cnt = 0; ks_pend = 1'b0;
        ks_ready = 1'b0; ks_vld = 1'b0;
        n_kv = 0; n_start = 0; n_req = 0; n_pr = 0; n_cw = 0; n_cr = 0; n_pw = 0; n_overlap = 0;
        for (int i = 0; i < 8; i++) begin
            cap_k[i] = 8'hee; cap_c[i] = 8'hee; cap_p[i] = 8'hee;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        clear_model();
    endtask

    task automatic send_key(input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            key_valid = 1'b1;
            key_in    = base + 8'(i);
            step();
        end
        key_valid = 1'b0;
        key_in    = 8'h00;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (all_out !== 33'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %0h expected 0", all_out);
        end
        rst = 1'b0;
        clear_model();
        step();
        checks++;
        if (all_out !== 33'd0) begin
            failures++;
            $display("FAIL idle_outputs: got %0h expected 0", all_out);
        end
    endtask

    task automatic test_key();
        bit ok;
        do_reset();
        host_plen = 0; host_clen = 0;
        for (int i = 0; i < 3; i++) begin
            key_valid = 1'b1;
            key_in    = 8'(i + 1);
            step();
            checks++;
            if (ks_key_valid !== 1'b1 || ks_key_in !== 8'(i + 1)) begin
                failures++;
                $display("FAIL key_fwd[%0d]: got v=%b d=%h expected v=1 d=%h",
                         i, ks_key_valid, ks_key_in, 8'(i + 1));
            end
        end
        key_valid = 1'b0;
        step();
        checks++;
        if (ks_key_valid !== 1'b0 || ks_start !== 1'b1) begin
            failures++;
            $display("FAIL key_end: got v=%b start=%b expected v=0 start=1", ks_key_valid, ks_start);
        end
        step();
        checks++;
        if (ks_start !== 1'b0) begin
            failures++;
            $display("FAIL start_pulse: got %b expected 0", ks_start);
        end
        wait_done(100, ok);
        checks++;
        if (!ok || n_start != 1 || n_kv != 3) begin
            failures++;
            $display("FAIL key_session: got done=%b starts=%0d keys=%0d expected 1 1 3",
                     ok, n_start, n_kv);
        end
    endtask

    task automatic test_key_saturate();
        bit ok;
        do_reset();
        host_plen = 0; host_clen = 0;
        send_key(6, 8'h01);
        wait_done(100, ok);
        checks++;
        if (!ok || n_kv != 4 || {cap_k[0], cap_k[1], cap_k[2], cap_k[3]} !== 32'h01020304) begin
            failures++;
            $display("FAIL key_saturate: got done=%b n=%0d bytes=%h expected 1 4 01020304",
                     ok, n_kv, {cap_k[0], cap_k[1], cap_k[2], cap_k[3]});
        end
    endtask

    task automatic test_two_byte();
        bit ok;
        do_reset();
        ks_tab[0] = 8'haa; ks_tab[1] = 8'h55;
        host_p[0] = 8'h00; host_p[1] = 8'h11; host_plen = 2;
        host_c[0] = 8'haa; host_c[1] = 8'h44; host_clen = 2;
        send_key(1, 8'h5a);
        wait_done(200, ok);
        checks++;
        if (!ok || err !== 1'b0) begin
            failures++;
            $display("FAIL two_done: got done=%b err=%b expected 1 0", ok, err);
        end
        checks++;
        if (n_cw != 2 || {cap_c[0], cap_c[1]} !== 16'haa44) begin
            failures++;
            $display("FAIL two_cipher: got n=%0d %h expected 2 aa44", n_cw, {cap_c[0], cap_c[1]});
        end
        checks++;
        if (n_pw != 2 || {cap_p[0], cap_p[1]} !== 16'h0011) begin
            failures++;
            $display("FAIL two_plain: got n=%0d %h expected 2 0011", n_pw, {cap_p[0], cap_p[1]});
        end
        checks++;
        if (n_start != 2 || n_req != 4 || n_overlap != 0) begin
            failures++;
            $display("FAIL two_strobes: got starts=%0d reqs=%0d overlap=%0d expected 2 4 0",
                     n_start, n_req, n_overlap);
        end
    endtask

    task automatic test_empty();
        bit ok;
        do_reset();
        host_plen = 0; host_clen = 4;
        send_key(2, 8'h30);
        wait_done(100, ok);
        checks++;
        if (!ok || err !== 1'b0 || n_cw != 0 || n_cr != 0 || n_pr != 1 || n_start != 1) begin
            failures++;
            $display("FAIL empty_msg: got done=%b err=%b cw=%0d cr=%0d pr=%0d st=%0d expected 1 0 0 0 1 1",
                     ok, err, n_cw, n_cr, n_pr, n_start);
        end
    endtask

    task automatic test_max_len();
        bit ok;
        do_reset();
        for (int i = 0; i < 8; i++) ks_tab[i] = 8'((i + 1) * 16);
        for (int i = 0; i < 6; i++) begin
            host_p[i] = 8'(i + 1);
            host_c[i] = 8'((i + 1) * 17);
        end
        host_plen = 6; host_clen = 6;
        send_key(3, 8'h10);
        wait_done(300, ok);
        checks++;
        if (!ok || err !== 1'b0) begin
            failures++;
            $display("FAIL max_done: got done=%b err=%b expected 1 0", ok, err);
        end
        checks++;
        if (n_cw != 4 || n_pr != 4 ||
            {cap_c[0], cap_c[1], cap_c[2], cap_c[3]} !== 32'h11223344) begin
            failures++;
            $display("FAIL max_encrypt: got cw=%0d pr=%0d %h expected 4 4 11223344",
                     n_cw, n_pr, {cap_c[0], cap_c[1], cap_c[2], cap_c[3]});
        end
        checks++;
        if (n_cr != 4 || n_pw != 4 || n_overlap != 0 ||
            {cap_p[0], cap_p[1], cap_p[2], cap_p[3]} !== 32'h01020304) begin
            failures++;
            $display("FAIL max_decrypt: got cr=%0d pw=%0d ov=%0d %h expected 4 4 0 01020304",
                     n_cr, n_pw, n_overlap, {cap_p[0], cap_p[1], cap_p[2], cap_p[3]});
        end
    endtask

    task automatic test_short_decrypt();
        bit ok;
        do_reset();
        ks_tab[0] = 8'haa; ks_tab[1] = 8'h55;
        host_p[0] = 8'h00; host_p[1] = 8'h11; host_plen = 2;
        host_c[0] = 8'haa; host_clen = 1;
        send_key(1, 8'h77);
        wait_done(200, ok);
        checks++;
        if (!ok || err !== 1'b1) begin
            failures++;
            $display("FAIL short_err: got done=%b err=%b expected 1 1", ok, err);
        end
        checks++;
        if (n_cw != 2 || n_cr != 2 || n_pw != 1 || cap_p[0] !== 8'h00) begin
            failures++;
            $display("FAIL short_counts: got cw=%0d cr=%0d pw=%0d p0=%h expected 2 2 1 00",
                     n_cw, n_cr, n_pw, cap_p[0]);
        end
    endtask

    task automatic test_abort();
        bit ok;
        bit seen;
        do_reset();
        ks_tab[0] = 8'haa; ks_tab[1] = 8'h55;
        host_p[0] = 8'h00; host_p[1] = 8'h11; host_plen = 2;
        host_c[0] = 8'haa; host_c[1] = 8'h44; host_clen = 2;
        send_key(1, 8'h42);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (ks_req) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL abort_reach_eks: got no ks_req expected ks_req");
        end
        rst = 1'b1;
        step();
        checks++;
        if (all_out !== 33'd0) begin
            failures++;
            $display("FAIL abort_outputs: got %0h expected 0", all_out);
        end
        rst = 1'b0;
        clear_model();
        host_plen = 2; host_clen = 2;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (n_req != 0 || n_start != 0 || all_out !== 33'd0) begin
            failures++;
            $display("FAIL abort_idle: got reqs=%0d starts=%0d out=%0h expected 0 0 0",
                     n_req, n_start, all_out);
        end
        send_key(1, 8'h42);
        wait_done(200, ok);
        checks++;
        if (!ok || err !== 1'b0 || {cap_c[0], cap_c[1]} !== 16'haa44 ||
            {cap_p[0], cap_p[1]} !== 16'h0011) begin
            failures++;
            $display("FAIL abort_resume: got done=%b err=%b c=%h p=%h expected 1 0 aa44 0011",
                     ok, err, {cap_c[0], cap_c[1]}, {cap_p[0], cap_p[1]});
        end
    endtask

    initial begin
        rst = 1'b1;
        key_valid = 1'b0;
        key_in = 8'h00;
        plain_in_valid = 1'b0;
        plain_in = 8'h00;
        cipher_in_valid = 1'b0;
        cipher_in = 8'h00;
        ks_ready = 1'b0;
        ks_vld = 1'b0;
        ks_byte = 8'h00;
        host_plen = 0;
        host_clen = 0;
        for (int i = 0; i < 8; i++) begin
            ks_tab[i] = 8'h00; host_p[i] = 8'h00; host_c[i] = 8'h00;
        end
        clear_model();
        test_reset();
        test_key();
        test_key_saturate();
        test_two_byte();
        test_empty();
        test_max_len();
        test_short_decrypt();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
